// File: rtl/adc_sched_pkg.sv
// Shared types and frame constants for the ADC scan arbiter.
// Also holds the MCP3008-style command bit lookup used during the SHIFT phase.
package adc_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARB      = 3'd1,
      ST_CS_SETUP = 3'd2,
      ST_SHIFT    = 3'd3,
      ST_DONE     = 3'd4,
      ST_GAP      = 3'd5
   } adc_state_e;

   localparam int   ADC_FRAME_PERIODS = 17;
   localparam int   FIRST_DATA_PERIOD = 8;
   localparam logic START_BIT         = 1'b1;

   // Command bit for a zero-based SCLK period index: start, mode, then channel MSB first.
   function automatic logic din_for_period(input logic [4:0] bit_idx,
                                           input logic       sgl,
                                           input logic [2:0] ch);
      logic bit_s;
      case (bit_idx)
         5'd0:    bit_s = START_BIT;
         5'd1:    bit_s = sgl;
         5'd2:    bit_s = ch[2];
         5'd3:    bit_s = ch[1];
         5'd4:    bit_s = ch[0];
         default: bit_s = 1'b0;
      endcase
      return bit_s;
   endfunction

endpackage

// File: rtl/half_period_tick.sv
// Counts CLK_DIV clk cycles while enabled; tick marks the last cycle of each
// SCLK half-period. Counter is held at zero whenever disabled.
module half_period_tick #(
   parameter int CLK_DIV = 27
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_r;

   assign tick = en && (cnt_r == CW'(CLK_DIV - 1));

   // Half-period counter, restarting at every tick and whenever disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (!en || tick) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

endmodule

// File: rtl/adc_scan_arbiter.sv
// Round-robin arbiter sharing one SPI ADC between four requesters; each grant runs
// one 17-period conversion frame and returns a 10-bit result tagged with the requester id.
module adc_scan_arbiter
   import adc_sched_pkg::*;
#(
   parameter int CLK_DIV = 27,
   parameter int N_REQ   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [3*N_REQ-1:0]   req_ch,
   input  logic [N_REQ-1:0]     req_sgl,
   output logic [N_REQ-1:0]     grant,
   output logic                 busy,
   output logic                 rd_valid,
   output logic [1:0]           rd_id,
   output logic [9:0]           rd_data,
   output logic                 adc_cs_n,
   output logic                 adc_sclk,
   output logic                 adc_din,
   input  logic                 adc_dout
);

   adc_state_e  state_r;
   logic [1:0]  rr_ptr_r;
   logic [2:0]  ch_r;
   logic        sgl_r;
   logic [4:0]  bit_cnt_r;
   logic        gap_half_r;
   logic        tick_en_s;
   logic        tick_s;
   logic [1:0]  win_s;

   // First requesting index at or after ptr; lowest offset is written last so it wins
   function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [1:0] ptr);
      logic [1:0] idx;
      logic [1:0] pick;
      pick = ptr;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (r[idx]) begin
            pick = idx;
         end
      end
      return pick;
   endfunction

   assign win_s     = rr_pick(req, rr_ptr_r);
   assign tick_en_s = (state_r == ST_CS_SETUP) || (state_r == ST_SHIFT) || (state_r == ST_GAP);

   half_period_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (tick_en_s),
      .tick  (tick_s)
   );

   // Transaction FSM with all ADC and handshake outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         rr_ptr_r   <= 2'd0;
         ch_r       <= 3'd0;
         sgl_r      <= 1'b0;
         bit_cnt_r  <= 5'd0;
         gap_half_r <= 1'b0;
         grant      <= '0;
         busy       <= 1'b0;
         rd_valid   <= 1'b0;
         rd_id      <= 2'd0;
         rd_data    <= 10'd0;
         adc_cs_n   <= 1'b1;
         adc_sclk   <= 1'b0;
         adc_din    <= 1'b0;
      end else begin
         grant    <= '0;
         rd_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               adc_cs_n <= 1'b1;
               adc_sclk <= 1'b0;
               adc_din  <= 1'b0;
               if (|req) begin
                  grant    <= N_REQ'(1) << win_s;
                  rd_id    <= win_s;
                  ch_r     <= req_ch[3*win_s +: 3];
                  sgl_r    <= req_sgl[win_s];
                  rr_ptr_r <= win_s + 2'd1;
                  busy     <= 1'b1;
                  state_r  <= ST_ARB;
               end else begin
                  state_r  <= ST_IDLE;
               end
            end
            ST_ARB: begin
               adc_cs_n <= 1'b0;
               state_r  <= ST_CS_SETUP;
            end
            ST_CS_SETUP: begin
               if (tick_s) begin
                  bit_cnt_r <= 5'd0;
                  adc_din   <= din_for_period(5'd0, sgl_r, ch_r);
                  state_r   <= ST_SHIFT;
               end else begin
                  state_r   <= ST_CS_SETUP;
               end
            end
            ST_SHIFT: begin
               if (tick_s && !adc_sclk) begin
                  adc_sclk <= 1'b1;
               end else if (tick_s) begin
                  // End of a high half: the ADC has had the whole half to settle dout
                  if (bit_cnt_r >= 5'(FIRST_DATA_PERIOD - 1)) begin
                     rd_data <= {rd_data[8:0], adc_dout};
                  end
                  adc_sclk <= 1'b0;
                  if (bit_cnt_r == 5'(ADC_FRAME_PERIODS - 1)) begin
                     adc_cs_n <= 1'b1;
                     adc_din  <= 1'b0;
                     rd_valid <= 1'b1;
                     state_r  <= ST_DONE;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + 5'd1;
                     adc_din   <= din_for_period(bit_cnt_r + 5'd1, sgl_r, ch_r);
                  end
               end else begin
                  state_r <= ST_SHIFT;
               end
            end
            ST_DONE: begin
               gap_half_r <= 1'b0;
               state_r    <= ST_GAP;
            end
            ST_GAP: begin
               if (tick_s && gap_half_r) begin
                  busy    <= 1'b0;
                  state_r <= ST_IDLE;
               end else if (tick_s) begin
                  gap_half_r <= 1'b1;
               end else begin
                  state_r <= ST_GAP;
               end
            end
            default: begin
               adc_cs_n <= 1'b1;
               adc_sclk <= 1'b0;
               adc_din  <= 1'b0;
               busy     <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_scan_arbiter.sv
// Self-checking bench: behavioural MCP3008-style ADC plus a round-robin scoreboard,
// driven by directed scenarios and randomized request patterns at CLK_DIV=2.
module tb_adc_scan_arbiter;

   localparam int CLK_DIV = 2;
   localparam int LATENCY = 35 * CLK_DIV + 1;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [11:0] req_ch;
   logic [3:0]  req_sgl;
   logic [3:0]  grant;
   logic        busy;
   logic        rd_valid;
   logic [1:0]  rd_id;
   logic [9:0]  rd_data;
   logic        adc_cs_n;
   logic        adc_sclk;
   logic        adc_din;
   logic        adc_dout;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rv_count = 0;
   int rr_m     = 0;

   logic [9:0] adc_val [8];
   int         frame_rises = 0;
   int         last_len    = 0;
   logic [4:0] din_cap     = 5'd0;
   logic [2:0] mch         = 3'd0;

   adc_scan_arbiter #(.CLK_DIV(CLK_DIV), .N_REQ(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_ch   (req_ch),
      .req_sgl  (req_sgl),
      .grant    (grant),
      .busy     (busy),
      .rd_valid (rd_valid),
      .rd_id    (rd_id),
      .rd_data  (rd_data),
      .adc_cs_n (adc_cs_n),
      .adc_sclk (adc_sclk),
      .adc_din  (adc_din),
      .adc_dout (adc_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;
   always @(negedge clk) if (rd_valid === 1'b1) rv_count++;

   // ADC model: samples DIN on SCLK rise, drives each result bit from the rise of its period
   always @(posedge adc_sclk or posedge adc_cs_n) begin
      if (adc_cs_n) begin
         last_len    = frame_rises;
         frame_rises = 0;
         adc_dout    = 1'b0;
      end else begin
         frame_rises++;
         if (frame_rises <= 5) din_cap[5 - frame_rises] = adc_din;
         if (frame_rises == 5) mch = din_cap[2:0];
         if (frame_rises >= 8 && frame_rises <= 17)
            adc_dout = adc_val[mch][17 - frame_rises];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One transaction: predict winner, wait for grant and result, compare against the model
   task automatic do_txn(input logic [3:0] mask, input bit drop, input string tag);
      int w, n, gc;
      logic [2:0] ch;
      logic       sg;
      logic [9:0] ed;
      w = 0;
      for (int i = 3; i >= 0; i--) if (mask[(rr_m + i) % 4]) w = (rr_m + i) % 4;
      req = mask;
      n = 0;
      while (grant === 4'b0000 && n < 300) begin @(negedge clk); n++; end
      check_eq({tag, "_grant_seen"}, 32'(grant !== 4'b0000), 32'd1);
      if (grant === 4'b0000) begin req = 4'b0000; return; end
      check_eq({tag, "_grant"}, 32'(grant), 32'(4'b0001 << w));
      check_eq({tag, "_cs_idle_at_grant"}, 32'(adc_cs_n), 32'd1);
      check_eq({tag, "_busy_at_grant"}, 32'(busy), 32'd1);
      ch = req_ch[3*w +: 3];
      sg = req_sgl[w];
      ed = adc_val[ch];
      gc = cyc;
      rr_m = (w + 1) % 4;
      if (drop) begin
         req     = 4'b0000;
         req_ch  = 12'($urandom);
         req_sgl = 4'($urandom);
      end
      n = 0;
      @(negedge clk);
      while (rd_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      check_eq({tag, "_rd_valid_seen"}, 32'(rd_valid), 32'd1);
      if (rd_valid !== 1'b1) return;
      check_eq({tag, "_latency"}, 32'(cyc - gc), 32'(LATENCY));
      check_eq({tag, "_rd_id"}, 32'(rd_id), 32'(w));
      check_eq({tag, "_rd_data"}, 32'(rd_data), 32'(ed));
      check_eq({tag, "_din_cmd"}, 32'(din_cap), 32'({1'b1, sg, ch}));
      check_eq({tag, "_frame_len"}, 32'(last_len), 32'd17);
   endtask

   initial begin
      int bad_cs, bad_sclk, bad_busy, bad_grant, n, rv0;
      logic [3:0] m;
      rst_n   = 1'b0;
      req     = 4'b0000;
      req_ch  = 12'd0;
      req_sgl = 4'b0000;
      for (int i = 0; i < 8; i++) adc_val[i] = 10'(i * 37);
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_cs_n", 32'(adc_cs_n), 32'd1);
      check_eq("rst_sclk", 32'(adc_sclk), 32'd0);
      check_eq("rst_din", 32'(adc_din), 32'd0);
      check_eq("rst_grant", 32'(grant), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
      check_eq("rst_rd_id", 32'(rd_id), 32'd0);
      check_eq("rst_rd_data", 32'(rd_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle: no requests for 1000 cycles
      bad_cs = 0; bad_sclk = 0; bad_busy = 0; bad_grant = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (adc_cs_n !== 1'b1) bad_cs++;
         if (adc_sclk !== 1'b0) bad_sclk++;
         if (busy !== 1'b0) bad_busy++;
         if (grant !== 4'b0000) bad_grant++;
      end
      check_eq("idle_cs_n", 32'(bad_cs), 32'd0);
      check_eq("idle_sclk", 32'(bad_sclk), 32'd0);
      check_eq("idle_busy", 32'(bad_busy), 32'd0);
      check_eq("idle_grant", 32'(bad_grant), 32'd0);

      // Single request: req[0], ch 5, single-ended
      adc_val[5] = 10'h2A5;
      req_ch = 12'd5;
      req_sgl = 4'b0001;
      do_txn(4'b0001, 1'b1, "single");

      // Requester 3, ch 7, differential, full-scale then zero
      req_ch = {3'd7, 9'd0};
      req_sgl = 4'b0000;
      adc_val[7] = 10'h3FF;
      do_txn(4'b1000, 1'b1, "r3_ff");
      req_ch = {3'd7, 9'd0};
      req_sgl = 4'b0000;
      adc_val[7] = 10'h000;
      do_txn(4'b1000, 1'b1, "r3_00");

      // All four held: strict rotation
      req_ch = {3'd3, 3'd2, 3'd1, 3'd0};
      req_sgl = 4'b1010;
      for (int i = 0; i < 4; i++) do_txn(4'b1111, (i == 3), "all4");

      // Requesters 0 and 2 held: alternation
      req_ch = {3'd6, 3'd0, 3'd4, 3'd1};
      req_sgl = 4'b0101;
      for (int i = 0; i < 8; i++) do_txn(4'b0101, (i == 7), "alt02");

      // Randomized masks, channels, modes and ADC values
      for (int i = 0; i < 12; i++) begin
         for (int c = 0; c < 8; c++) adc_val[c] = 10'($urandom);
         req_ch  = 12'($urandom);
         req_sgl = 4'($urandom);
         m = 4'($urandom_range(1, 15));
         do_txn(m, 1'b1, "rnd");
      end

      // Reset during SHIFT period 9
      req_ch = 12'd2;
      req_sgl = 4'b0001;
      req = 4'b0001;
      n = 0;
      while (grant === 4'b0000 && n < 300) begin @(negedge clk); n++; end
      req = 4'b0000;
      n = 0;
      while (frame_rises != 9 && n < 300) begin @(negedge clk); n++; end
      check_eq("rst_mid_reached_p9", 32'(frame_rises), 32'd9);
      rv0 = rv_count;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_cs_n", 32'(adc_cs_n), 32'd1);
      check_eq("rst_mid_sclk", 32'(adc_sclk), 32'd0);
      check_eq("rst_mid_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rr_m = 0;
      repeat (100) @(negedge clk);
      check_eq("rst_mid_no_rd_valid", 32'(rv_count - rv0), 32'd0);
      req_ch = {3'd5, 3'd1, 3'd3, 3'd6};
      req_sgl = 4'b1111;
      do_txn(4'b1010, 1'b1, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_scan_arbiter.md
ADC_SCAN_ARBITER -- requirements
Module: adc_scan_arbiter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 27, meaning clk cycles per SCLK half-period; legal range 2..255.
REQ-002 SHALL have parameter N_REQ, default 4, meaning number of requesters; fixed at 4 in this revision.
REQ-003 SHALL have one clock and one reset: clk and rst_n; reset is asynchronous, active-low.
REQ-004 clk  input  1  system clock (27 MHz board clock).
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  4  per-requester conversion request, level, held until granted.
REQ-007 req_ch  input  12  3-bit ADC channel per requester; requester i uses bits [3i+2:3i].
REQ-008 req_sgl  input  4  per-requester mode: 1 = single-ended, 0 = differential.
REQ-009 grant  output  4  one-hot, one-cycle pulse on acceptance of a request.
REQ-010 busy  output  1  high from grant cycle until end of GAP.
REQ-011 rd_valid  output  1  one-cycle pulse, result available.
REQ-012 rd_id  output  2  requester index of the result; valid with rd_valid.
REQ-013 rd_data  output  10  conversion result, MSB first from the ADC; valid with rd_valid.
REQ-014 adc_cs_n  output  1  ADC chip select, active low.
REQ-015 adc_sclk  output  1  ADC serial clock.
REQ-016 adc_din  output  1  ADC command data.
REQ-017 adc_dout  input  1  ADC result data.

Function
REQ-018 SHALL be an FSM with states IDLE, ARB, CS_SETUP, SHIFT, DONE, GAP.
REQ-019 IDLE -> ARB when any req bit is high; otherwise stays IDLE with adc_cs_n=1, adc_sclk=0, adc_din=0.
REQ-020 ARB lasts one cycle and grants the first requesting index at or after rr_ptr, wrapping 3 -> 0; it latches that requester's channel, mode and id; it sets rr_ptr to granted index + 1 mod 4.
REQ-021 CS_SETUP: adc_cs_n low and adc_sclk low for CLK_DIV cycles, starting on the cycle after grant (G+1).
REQ-022 SHIFT: 17 SCLK periods; each period is CLK_DIV cycles low, then CLK_DIV cycles high.
REQ-023 adc_din SHALL be constant for the whole of period k: k=1 start=1, k=2 sgl, k=3..5 channel bits D2, D1, D0; periods 6..17 drive 0.
REQ-024 adc_dout SHALL be captured on the last clk cycle of the high half of periods 8..17, into rd_data bits 9..0 respectively.
REQ-025 DONE: one cycle at G+35*CLK_DIV+1; adc_cs_n=1, rd_valid=1, with rd_id and rd_data stable.
REQ-026 GAP: 2*CLK_DIV cycles with adc_cs_n=1; then IDLE.
REQ-027 A req still high after its result is treated as a new request; there is no queueing beyond the level of req.
REQ-028 Changes to req, req_ch or req_sgl after ARB SHALL NOT affect the transaction in flight.
REQ-029 Half-period counter width SHALL be $clog2(CLK_DIV); bit counter width SHALL be 5 bits, counting 0..16.

Reset
REQ-030 rst_n low SHALL immediately set: state=IDLE, adc_cs_n=1, adc_sclk=0, adc_din=0, grant=0, busy=0, rd_valid=0, rd_id=0, rd_data=0, rr_ptr=0, all counters=0.
REQ-031 Reset mid-transaction aborts it with no rd_valid; the first grant after release follows rr_ptr=0.

Structure
REQ-032 Package adc_sched_pkg SHALL hold the state enum, ADC_FRAME_PERIODS=17, FIRST_DATA_PERIOD=8 and START_BIT=1.
REQ-033 Sub-module half_period_tick SHALL generate the CLK_DIV tick; all other logic lives in adc_scan_arbiter.

Verification (CLK_DIV=2, behavioural MCP3008 model)
REQ-034 Single request, req[0] with ch=5, sgl=1, model value 0x2A5 -> DIN periods 1..5 = 1,1,1,0,1; rd_valid exactly 71 cycles after grant; rd_id=0; rd_data=0x2A5.
REQ-035 req=4'b1111 all held -> grants in order 0, 1, 2, 3, each followed by its rd_valid with matching rd_id; no overlap of adc_cs_n low windows.
REQ-036 req[0] and req[2] continuously high -> grants alternate 0, 2, 0, 2 for 8 transactions.
REQ-037 rst_n asserted during SHIFT period 9 -> adc_cs_n=1 and adc_sclk=0 without waiting for clk; no rd_valid; after release, req=4'b1010 grants 1 first.
REQ-038 req=0 for 1000 cycles -> adc_cs_n stays 1, adc_sclk stays 0, busy stays 0, grant stays 0.
REQ-039 req[3] with ch=7, sgl=0, model value 0x3FF, then model value 0x000 -> DIN periods 1..5 = 1,0,1,1,1; rd_data=0x3FF and then 0x000.
